// File: rtl/kmeans_update_k2_d2_pkg.sv
// Shared types and sizing helpers for the k=2, d=2 k-means
// centroid-update stage and its serial divider.
package kmeans_update_k2_d2_pkg;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;
  localparam int S      = DATA_W + CNT_W;

  function automatic int sum_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int div_iters(input int sw);
    return sw;
  endfunction

endpackage

// File: rtl/kmeans_update_k2_d2_divider.sv
// Unsigned restoring divider: one load cycle, then one
// quotient bit per cycle; done marks the final iteration.
module serial_divider_u
  import kmeans_update_k2_d2_pkg::*;
#(
  parameter int sw = S,
  parameter int cw = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [sw-1:0] dividend,
  input  logic [cw-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [sw-1:0] quotient
);

  localparam int IW = $clog2(div_iters(sw) + 1);

  logic [cw-1:0] rem;
  logic [cw-1:0] dvs;
  logic [sw-1:0] quo;
  logic [sw-1:0] quo_n;
  logic [IW-1:0] iter;
  logic [cw:0]   sh;
  logic [cw:0]   diff;
  logic          ge;
  logic          unused_msb;

  assign sh         = {rem, quo[sw-1]};
  assign diff       = sh - {1'b0, dvs};
  assign ge         = sh >= {1'b0, dvs};
  assign quo_n      = {quo[sw-2:0], ge};
  assign done       = busy && (iter == IW'(1));
  // Final quotient is exposed during the last iteration cycle
  assign quotient   = busy ? quo_n : quo;
  assign unused_msb = diff[cw];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dvs  <= '0;
      quo  <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      rem  <= '0;
      dvs  <= divisor;
      quo  <= dividend;
      iter <= IW'(div_iters(sw));
      busy <= 1'b1;
    end else if (busy) begin
      rem  <= ge ? diff[cw-1:0] : sh[cw-1:0];
      quo  <= quo_n;
      iter <= iter - IW'(1);
      busy <= !done;
    end
  end

endmodule

// File: rtl/kmeans_update_k2_d2.sv
// Centroid update: accumulate classified samples, then divide
// sums by counts serially to produce the next centroids.
module kmeans_update_k2_d2
  import kmeans_update_k2_d2_pkg::*;
#(
  parameter int input_data_width = DATA_W,
  parameter int count_width      = CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic [input_data_width-1:0] input_data0,
  input  logic [input_data_width-1:0] input_data1,
  input  logic                        selected_centroid,
  input  logic [input_data_width-1:0] centroid0_d0,
  input  logic [input_data_width-1:0] centroid0_d1,
  input  logic [input_data_width-1:0] centroid1_d0,
  input  logic [input_data_width-1:0] centroid1_d1,
  output logic [input_data_width-1:0] new_centroid0_d0,
  output logic [input_data_width-1:0] new_centroid0_d1,
  output logic [input_data_width-1:0] new_centroid1_d0,
  output logic [input_data_width-1:0] new_centroid1_d1,
  output logic [count_width-1:0]      count0,
  output logic [count_width-1:0]      count1,
  output logic                        update_valid,
  output logic                        overflow
);

  localparam int sw = sum_w(input_data_width, count_width);
  localparam int DW = input_data_width;
  localparam logic [count_width-1:0] CMAX = '1;

  state_t                 state_q, state_d;
  logic [sw-1:0]          sum [4];
  logic [count_width-1:0] cnt [2];
  logic [DW-1:0]          snap [4];
  logic [DW-1:0]          stage [4];
  logic [DW-1:0]          nc [4];
  logic [1:0]             idx;
  logic [sw-1:0]          quo;
  logic [DW-1:0]          res;
  logic [1:0]             i0, i1;
  logic                   busy, done, start;
  logic                   accept, sat;
  logic                   unused_hi;

  assign in_ready  = state_q == ACC;
  assign accept    = in_ready && in_valid;
  assign sat       = cnt[selected_centroid] == CMAX;
  assign start     = (state_q == DIV) && !busy;
  assign i0        = {selected_centroid, 1'b0};
  assign i1        = {selected_centroid, 1'b1};
  // Empty cluster keeps its previous centroid
  assign res       = (cnt[idx[1]] == '0) ? snap[idx]
                                         : quo[DW-1:0];
  assign unused_hi = ^quo[sw-1:DW];

  assign new_centroid0_d0 = nc[0];
  assign new_centroid0_d1 = nc[1];
  assign new_centroid1_d0 = nc[2];
  assign new_centroid1_d1 = nc[3];

  serial_divider_u #(
    .sw (sw),
    .cw (count_width)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (sum[idx]),
    .divisor  (cnt[idx[1]]),
    .busy     (busy),
    .done     (done),
    .quotient (quo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (accept && in_last) state_d = DIV;
      DIV:     if (done && idx == 2'd3) state_d = DONE;
      DONE:    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      update_valid <= 1'b0;
      overflow     <= 1'b0;
      count0       <= '0;
      count1       <= '0;
      cnt[0]       <= '0;
      cnt[1]       <= '0;
      for (int i = 0; i < 4; i++) begin
        sum[i]   <= '0;
        snap[i]  <= '0;
        stage[i] <= '0;
        nc[i]    <= '0;
      end
    end else begin
      update_valid <= 1'b0;
      if (accept) begin
        if (sat) begin
          overflow <= 1'b1;
        end else begin
          sum[i0] <= sum[i0]
                   + {{count_width{1'b0}}, input_data0};
          sum[i1] <= sum[i1]
                   + {{count_width{1'b0}}, input_data1};
          cnt[selected_centroid] <=
            cnt[selected_centroid] + count_width'(1);
        end
        if (in_last) begin
          snap[0] <= centroid0_d0;
          snap[1] <= centroid0_d1;
          snap[2] <= centroid1_d0;
          snap[3] <= centroid1_d1;
          idx     <= '0;
        end
      end
      if (state_q == DIV && done) begin
        stage[idx] <= res;
        idx        <= idx + 2'd1;
        // Publish on entry to DONE so outputs are valid with the pulse
        if (idx == 2'd3) begin
          nc[0]        <= stage[0];
          nc[1]        <= stage[1];
          nc[2]        <= stage[2];
          nc[3]        <= res;
          count0       <= cnt[0];
          count1       <= cnt[1];
          update_valid <= 1'b1;
        end
      end
      if (state_q == DONE) begin
        overflow <= 1'b0;
        cnt[0]   <= '0;
        cnt[1]   <= '0;
        for (int i = 0; i < 4; i++) sum[i] <= '0;
      end
    end
  end

endmodule

// File: doc/kmeans_update_k2_d2.md
# kmeans_update_k2_d2

Centroid-update stage that sits directly downstream of the k=2, d=2 k-means distance/assignment pipeline. It accumulates each classified sample into the sums of its selected centroid. At end of pass it computes new centroids as per-dimension means with a shared serial restoring divider, then presents them for the next iteration. Unsigned fixed-width data throughout.

## Interface
- `input_data_width`, 16, width of each sample/centroid coordinate
- `count_width`, 16, width of per-centroid sample counter; sum width `S = input_data_width + count_width`
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `in_valid`  in  1  sample valid, aligned with pipeline outputs (upstream controller delays its valid by the pipeline latency of 4)
- `in_last`  in  1  qualifies the final sample of a pass; meaningful only with `in_valid`
- `in_ready`  out  1  high when samples are accepted (state ACC)
- `input_data0`, `input_data1`  in  input_data_width  sample coordinates from the upstream pipeline
- `selected_centroid`  in  1  nearest-centroid index from the upstream pipeline
- `centroid0_d0`, `centroid0_d1`, `centroid1_d0`, `centroid1_d1`  in  input_data_width  current centroids, used as fallback for empty clusters
- `new_centroid0_d0` … `new_centroid1_d1`  out  input_data_width  registered updated centroids
- `count0`, `count1`  out  count_width  samples assigned per centroid in the last completed pass
- `update_valid`  out  1  one-cycle pulse when the new centroid and count outputs change
- `overflow`  out  1  sticky per pass; some sample was dropped due to counter saturation

## Operation
- States: ACC → DIV → DONE → ACC. Reset state is ACC.
- ACC: on `in_valid`, add each coordinate to `sum_k{sel}_d{0,1}` (S bits). Increment `cnt_k{sel}`.
  - If `cnt_k{sel}` equals `2^count_width − 1`, drop the sample (no sum or count change) and set `overflow`.
  - With `in_last`, the sample is still accumulated. The old centroids are snapshotted in the same cycle, and the next state is DIV.
- DIV: four quotients are computed in fixed order k0d0, k0d1, k1d0, k1d1.
  - Each quotient takes 1 load cycle followed by S restoring iterations, one quotient bit per cycle, for S+1 cycles each.
  - Quotient = floor(sum / cnt), truncated to the low `input_data_width` bits. This is lossless because the mean never exceeds the maximum input.
  - When cnt = 0, the full S+1 cycles are still spent. The result is the snapshotted old centroid.
  - Results go into staging registers.
- DONE, one cycle:
  - Staging registers are copied to `new_centroid*`, and `cnt_k*` to `count*`.
  - `update_valid` = 1.
  - Sums and counts are cleared, and `overflow` is cleared.
  - Next state: ACC.
- In DIV and DONE, `in_valid` is ignored and no accumulation occurs.
- Reset at any time, including mid-DIV:
  - State returns to ACC; sums, counts and staging registers are cleared.
  - All outputs take their reset values; no `update_valid` is produced.

## Timing
- Reset values: `new_centroid*` = 0, `count*` = 0, `update_valid` = 0, `overflow` = 0, `in_ready` = 1.
- Sample accepted at edge t (with `in_valid`, in ACC) is reflected in the sums from cycle t+1.
- If `in_last` is accepted at edge t:
  - DIV occupies cycles t+1 … t+4(S+1). With defaults, S = 32, so that is 132 cycles.
  - DONE is cycle t+4(S+1)+1. `update_valid` is high in that cycle, and the new outputs are visible from that cycle.
  - `in_ready` returns high at cycle t+4(S+1)+2.
- `in_ready` is low for exactly 4(S+1)+1 cycles per pass.
- Back-to-back passes: the first sample of the next pass may be accepted in the first cycle `in_ready` is high.
- `in_last` on a cycle without `in_valid` has no effect.

## Structure
- Shared package holds:
  - state encoding (ACC, DIV, DONE)
  - a sum-width helper constant `S`
  - divider iteration count
- Natural sub-module: `serial_divider_u`, an unsigned restoring divider with ports:
  - `start`, `dividend[S]`, `divisor[count_width]`, `busy`, `done`, `quotient[S]`
  - fixed S+1 cycle latency and synchronous reset
- The top level instantiates the divider once and muxes the four sum/count pairs into it.

## Test plan
- Reset then idle:
  - All outputs are at reset values.
  - `in_ready` = 1, with no `update_valid` for 200 cycles.
- Basic pass:
  - Samples (10,20) sel0, (30,40) sel0, (100,200) sel1 + `in_last`.
  - Required result: `update_valid` exactly 133 cycles after the last accept.
  - new c0 = (20,30), c1 = (100,200), counts = (2,1).
- Truncation: samples (1,2) and (2,2), both sel0 and the second with `in_last` → c0 = (1,2).
- Empty cluster:
  - Old c1 = (7,9); all samples sel0, e.g. (4,4) + `in_last`.
  - Required result: new c1 = (7,9), `count1` = 0, c0 = (4,4).
- Ignored input and reset mid-DIV:
  - Drive `in_valid` during DIV → no effect on the next pass's sums.
  - Assert `rst` at DIV cycle 50 → no `update_valid`, outputs = 0, `in_ready` = 1 the next cycle.
- Saturation with `count_width` = 2:
  - Send four sel0 samples of (8,8) + `in_last`.
  - Required result: `count0` = 3, c0 = (8,8), `overflow` = 1 before DONE and 0 after it.
